// File: rtl/alzette_ise_iter.sv
// alzette_ise_iter: iterative Alzette ARX-box, QPC quarters per cycle, IDLE/BUSY/DONE handshake.
// Define ALZETTE_ISE_ITER_DEC_EN to include the inverse (decrypt) datapath.

module alzette_quarter (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] c,
  input  logic [1:0]  k,
  input  logic        enc,
  output logic [31:0] x_nxt,
  output logic [31:0] y_nxt
);
  function automatic logic [31:0] ror(input logic [31:0] v, input logic [4:0] n);
    logic [63:0] d;
    d = {v, v} >> n;
    return d[31:0];
  endfunction

  logic [1:0]  kf;
  logic [4:0]  r, s;
  logic [31:0] t;

`ifdef ALZETTE_ISE_ITER_DEC_EN
  // inverse quarter k undoes forward quarter 3-k, so it shares that rotation pair
  assign kf = enc ? k : ~k;
`else
  logic unused_enc;
  assign unused_enc = enc;
  assign kf = k;
`endif

  always_comb begin
    case (kf)
      2'd0:    begin r = 5'd31; s = 5'd24; end
      2'd1:    begin r = 5'd17; s = 5'd17; end
      2'd2:    begin r = 5'd0;  s = 5'd31; end
      default: begin r = 5'd24; s = 5'd16; end
    endcase
  end

  always_comb begin
    t     = '0;
    x_nxt = '0;
    y_nxt = '0;
`ifdef ALZETTE_ISE_ITER_DEC_EN
    if (!enc) begin
      t     = x ^ c;
      y_nxt = y ^ ror(t, s);
      x_nxt = t - ror(y_nxt, r);
    end else begin
      t     = x + ror(y, r);
      y_nxt = y ^ ror(t, s);
      x_nxt = t ^ c;
    end
`else
    t     = x + ror(y, r);
    y_nxt = y ^ ror(t, s);
    x_nxt = t ^ c;
`endif
  end
endmodule

module alzette_ise_iter #(
  parameter int QPC  = 1,
  parameter int XLEN = 64
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            op_enc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            out_err
);
  if (!((QPC == 1) || (QPC == 2) || (QPC == 4)) || (XLEN != 64)) begin : g_param_check
    $fatal(1, "alzette_ise_iter: QPC must be 1, 2 or 4 and XLEN must be 64");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [31:0] x_q, y_q, c_q;
  logic        enc_q, err_q;
  logic [1:0]  qcnt;
  logic        last;
  logic [31:0] x_res, y_res;
  logic        unused_rs2_hi;

  assign unused_rs2_hi = ^rs2[XLEN-1:32];

  // QPC quarters chained combinationally; quarter index of stage i is qcnt+i
  for (genvar i = 0; i < QPC; i++) begin : g_q
    logic [31:0] xi, yi, xo, yo;
    if (i == 0) begin : g_first
      assign xi = x_q;
      assign yi = y_q;
    end else begin : g_chain
      assign xi = g_q[i-1].xo;
      assign yi = g_q[i-1].yo;
    end
    alzette_quarter u_q (
      .x     (xi),
      .y     (yi),
      .c     (c_q),
      .k     (qcnt + 2'(i)),
      .enc   (enc_q),
      .x_nxt (xo),
      .y_nxt (yo)
    );
  end

  assign x_res = g_q[QPC-1].xo;
  assign y_res = g_q[QPC-1].yo;
  assign last  = (qcnt == 2'(4 - QPC));

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      rd        <= '0;
      qcnt      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      c_q       <= '0;
      enc_q     <= 1'b0;
      err_q     <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      qcnt      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_q      <= rs1[31:0];
          y_q      <= rs1[63:32];
          c_q      <= rs2[31:0];
          enc_q    <= op_enc;
          qcnt     <= '0;
`ifdef ALZETTE_ISE_ITER_DEC_EN
          err_q    <= 1'b0;
`else
          err_q    <= ~op_enc;
`endif
          in_ready <= 1'b0;
          state    <= BUSY;
        end
        BUSY: begin
          if (err_q) begin
            // unsupported direction: report after one cycle with a zero result
            rd        <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            x_q  <= x_res;
            y_q  <= y_res;
            qcnt <= qcnt + 2'(QPC);
            if (last) begin
              rd        <= {y_res, x_res};
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          out_err   <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_err   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alzette_ise_iter.sv
// Directed bench for alzette_ise_iter (QPC=1): known vectors, handshake, flush, async reset.
module tb_alzette_ise_iter;
  localparam int QPC = 1;
  localparam int LAT = 4 / QPC;
  localparam int RF[4] = '{31, 17, 0, 24};
  localparam int SF[4] = '{24, 17, 31, 16};

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        in_valid, in_ready, op_enc, flush, out_valid, out_ready, out_err;
  logic [63:0] rs1, rs2, rd;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_v, held;

  always #5 g_clk = ~g_clk;

  alzette_ise_iter #(.QPC(QPC), .XLEN(64)) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .op_enc    (op_enc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .out_err   (out_err)
  );

  function automatic logic [31:0] rr(logic [31:0] v, int n);
    return (v >> n) | (v << ((32 - n) % 32));
  endfunction

  function automatic logic [63:0] fwd(logic [63:0] st, logic [31:0] c);
    logic [31:0] x, y;
    x = st[31:0];
    y = st[63:32];
    for (int k = 0; k < 4; k++) begin
      x = x + rr(y, RF[k]);
      y = y ^ rr(x, SF[k]);
      x = x ^ c;
    end
    return {y, x};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic issue(logic [63:0] a, logic [63:0] b, logic enc);
    in_valid = 1'b1;
    rs1      = a;
    rs2      = b;
    op_enc   = enc;
    step();
    in_valid = 1'b0;
    rs1      = {$urandom, $urandom};
    rs2      = {$urandom, $urandom};
    op_enc   = ~enc;
  endtask

  task automatic run(string tag, logic [63:0] a, logic [63:0] b, logic enc,
                     logic [63:0] exp, logic err, int lat);
    issue(a, b, enc);
    check({tag, " in_ready busy"}, 64'(in_ready), 64'd0);
    repeat (lat - 1) step();
    if (lat > 1) check({tag, " early out_valid"}, 64'(out_valid), 64'd0);
    step();
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " rd"}, rd, exp);
    check({tag, " out_err"}, 64'(out_err), 64'(err));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    g_resetn = 1'b1; in_valid = 1'b0; op_enc = 1'b1; flush = 1'b0; out_ready = 1'b0;
    rs1 = '0; rs2 = '0;
    #2 g_resetn = 1'b0;
    #10;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset rd", rd, 64'd0);
    check("reset out_err", 64'(out_err), 64'd0);
    #6 g_resetn = 1'b1;
    step();
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    run("zero", 64'h0, 64'h0, 1'b1, 64'h0, 1'b0, LAT);
    run("c=1", 64'h0, 64'h1, 1'b1, 64'h80008180_01808000, 1'b0, LAT);
    run("y=1", 64'h00000001_00000000, 64'hDEADBEEF_00000000, 1'b1,
        64'hC847448E_43090A45, 1'b0, LAT);
    exp_v = fwd(64'h01234567_89ABCDEF, 32'hB7E15162);
    run("spec fwd", 64'h01234567_89ABCDEF, 64'h00000000_B7E15162, 1'b1, exp_v, 1'b0, LAT);

`ifdef ALZETTE_ISE_ITER_DEC_EN
    run("roundtrip dec", exp_v, 64'hFFFFFFFF_B7E15162, 1'b0, 64'h01234567_89ABCDEF, 1'b0, LAT);
    run("dec c=1", 64'h80008180_01808000, 64'h1, 1'b0, 64'h0, 1'b0, LAT);
`else
    run("dec absent", 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_B7E15162, 1'b0, 64'h0, 1'b1, 1);
`endif

    // back-pressure: result held while the source keeps pushing
    issue(64'h0, 64'h1, 1'b1);
    repeat (LAT) step();
    check("bp out_valid", 64'(out_valid), 64'd1);
    held = 64'h80008180_01808000;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      rs1 = {$urandom, $urandom};
      step();
      check("bp rd stable", rd, held);
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp out_valid held", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp delivered once", 64'(out_valid), 64'd0);
    step();
    step();
    check("bp no second result", 64'(out_valid), 64'd0);
    check("bp idle", 64'(in_ready), 64'd1);

    // flush on the second BUSY cycle with a new request pending
    in_valid = 1'b1; rs1 = 64'h0; rs2 = 64'h1; op_enc = 1'b1;
    step();
    rs1 = 64'h00000001_00000000;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush in_ready", 64'(in_ready), 64'd1);
    check("flush out_valid", 64'(out_valid), 64'd0);
    step();
    check("flush not accepted", 64'(in_ready), 64'd1);
    repeat (LAT) step();
    check("flush no result", 64'(out_valid), 64'd0);
    run("post-flush", 64'h00000001_00000000, 64'h0, 1'b1, 64'hC847448E_43090A45, 1'b0, LAT);

    // asynchronous reset mid-BUSY
    issue(64'h0, 64'h1, 1'b1);
    step();
    #2 g_resetn = 1'b0;
    #1;
    check("areset out_valid", 64'(out_valid), 64'd0);
    check("areset rd", rd, 64'd0);
    check("areset in_ready", 64'(in_ready), 64'd1);
    #3 g_resetn = 1'b1;
    step();
    check("areset release in_ready", 64'(in_ready), 64'd1);
    repeat (LAT) step();
    check("areset dropped", 64'(out_valid), 64'd0);

    run("final", 64'h0, 64'h1, 1'b1, 64'h80008180_01808000, 1'b0, LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
